// File: rtl/mult_pipe_tree.sv
// Pipelined WIDTH x WIDTH multiplier with optional Baugh-Wooley signed mode.
// S1 registers operands, S2 registers the two carry-save rows left by the
// HA/FA compression, S3 registers the Kogge-Stone carry-propagate sum.
// The whole pipe stalls together on output backpressure.

// Half adder cell
module mult_pipe_tree_ha (
  input  logic a,
  input  logic b,
  output logic carry,
  output logic sum
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// Full adder cell
module mult_pipe_tree_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic carry,
  output logic sum
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module mult_pipe_tree #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o
);
  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH + 1;  // WIDTH product rows plus the correction row
  localparam int LV   = $clog2(PW);

  logic             adv;
  logic             v1_q, v2_q, v3_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic             sgn_q;
  logic [PW-1:0]    sum_q, carry_q;
  logic [PW-1:0]    o_q;
  logic [PW-1:0]    fin_d;

  logic [PW-1:0]    pp   [ROWS];
  logic [PW-1:0]    ts   [1:ROWS-1];
  logic [PW-1:0]    tc   [1:ROWS-1];
  logic [PW-1:0]    cout [1:ROWS-1];
  logic [ROWS-1:1]  unused_top_carry;

  logic [PW-1:0]    gk [LV+1];
  logic [PW-1:0]    pk [LV+1];

  assign adv       = !(v3_q && !out_ready);
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign o         = o_q;

  if (SIGNED_EN != 0) begin : g_sgn
    // Per-transaction signed flag travels with the operands
    always_ff @(posedge clk) begin
      if (adv) sgn_q <= sgn;
    end
  end else begin : g_nosgn
    assign sgn_q = 1'b0;
  end

  // Operand and carry-save row registers; contents only matter when valid
  always_ff @(posedge clk) begin
    if (adv) begin
      x_q     <= x;
      y_q     <= y;
      sum_q   <= ts[ROWS-1];
      carry_q <= tc[ROWS-1];
    end
  end

  // Valid bits and product register; the whole pipe moves on adv
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      o_q  <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      o_q  <= fin_d;
    end
  end

  // Partial products; in signed mode the mixed MSB row/column terms are
  // inverted and the last row carries the 2^WIDTH + 2^(2*WIDTH-1) constant
  always_comb begin
    for (int unsigned i = 0; i < ROWS; i++) pp[i] = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (x_q[j] & y_q[i])
                   ^ (sgn_q & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    pp[WIDTH][WIDTH]  = sgn_q;
    pp[WIDTH][PW-1]   = sgn_q;
  end

  // Carry-save reduction: each level folds one more row into (ts, tc);
  // carries out of the top bit fall outside the modulo-2^PW result
  for (genvar k = 1; k < ROWS; k++) begin : g_lvl
    for (genvar b = 0; b < PW; b++) begin : g_bit
      if (k == 1) begin : g_h
        mult_pipe_tree_ha u_ha (
          .a(pp[0][b]), .b(pp[1][b]), .carry(cout[k][b]), .sum(ts[k][b])
        );
      end else begin : g_f
        mult_pipe_tree_fa u_fa (
          .a(ts[k-1][b]), .b(tc[k-1][b]), .c(pp[k][b]),
          .carry(cout[k][b]), .sum(ts[k][b])
        );
      end
    end
    assign tc[k]               = {cout[k][PW-2:0], 1'b0};
    assign unused_top_carry[k] = cout[k][PW-1];
  end

  // Kogge-Stone prefix adder over the registered carry-save rows
  always_comb begin
    gk[0] = sum_q & carry_q;
    pk[0] = sum_q ^ carry_q;
    for (int unsigned l = 0; l < LV; l++) begin
      gk[l+1] = gk[l];
      pk[l+1] = pk[l];
      for (int unsigned i = (32'd1 << l); i < PW; i++) begin
        gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(32'd1<<l)]);
        pk[l+1][i] = pk[l][i] & pk[l][i-(32'd1<<l)];
      end
    end
    fin_d = pk[0] ^ {gk[LV][PW-2:0], 1'b0};
  end

endmodule

// File: tb/tb_mult_pipe_tree.sv
// Bench for mult_pipe_tree: five instances (4/8/16/32-bit signed-capable and
// an 8-bit unsigned-only build) share one stream of stimulus and handshakes.
module tb_mult_pipe_tree;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, sgn;
  logic [31:0] xs, ys;
  logic        rdy [5];
  logic        ov  [5];
  logic [7:0]  o4;
  logic [15:0] o8, o8u;
  logic [31:0] o16;
  logic [63:0] o32;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mult_pipe_tree #(.WIDTH(4), .SIGNED_EN(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .x(xs[3:0]), .y(ys[3:0]), .sgn(sgn), .out_valid(ov[0]),
    .out_ready(out_ready), .o(o4));
  mult_pipe_tree #(.WIDTH(8), .SIGNED_EN(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .x(xs[7:0]), .y(ys[7:0]), .sgn(sgn), .out_valid(ov[1]),
    .out_ready(out_ready), .o(o8));
  mult_pipe_tree #(.WIDTH(16), .SIGNED_EN(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .x(xs[15:0]), .y(ys[15:0]), .sgn(sgn), .out_valid(ov[2]),
    .out_ready(out_ready), .o(o16));
  mult_pipe_tree #(.WIDTH(32), .SIGNED_EN(1)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]),
    .x(xs), .y(ys), .sgn(sgn), .out_valid(ov[3]),
    .out_ready(out_ready), .o(o32));
  mult_pipe_tree #(.WIDTH(8), .SIGNED_EN(0)) u8u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[4]),
    .x(xs[7:0]), .y(ys[7:0]), .sgn(sgn), .out_valid(ov[4]),
    .out_ready(out_ready), .o(o8u));

  function automatic int dw(int d);
    case (d)
      0: return 4;
      1: return 8;
      2: return 16;
      3: return 32;
      default: return 8;
    endcase
  endfunction

  function automatic logic se(int d);
    return (d != 4);
  endfunction

  function automatic logic [63:0] dut_o(int d);
    case (d)
      0: return 64'(o4);
      1: return 64'(o8);
      2: return 64'(o16);
      3: return o32;
      default: return 64'(o8u);
    endcase
  endfunction

  // Reference product: extend both operands to 64 bits, multiply, truncate
  function automatic logic [63:0] ref_prod(int w, logic [31:0] a, logic [31:0] b, logic s);
    logic [63:0] opm, ea, eb, p;
    opm = (64'd1 << w) - 64'd1;
    ea  = {32'b0, a} & opm;
    eb  = {32'b0, b} & opm;
    if (s && ea[w-1]) ea = ea | ~opm;
    if (s && eb[w-1]) eb = eb | ~opm;
    p = ea * eb;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic chk(string nm, int d, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, got, exp);
    end
  endtask

  // Transaction-level model: three slots that shift whenever the pipe moves
  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
  } slot_t;

  slot_t m_st [3];
  logic  m_zero = 1'b0;
  logic  m_init = 1'b0;
  logic  m_adv;

  logic [63:0] logq [5][$];
  int          logc [5][$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int k = 0; k < 3; k++) m_st[k].v = 1'b0;
      m_zero = 1'b1;
      m_init = 1'b1;
    end else if (!(m_st[2].v && !out_ready)) begin
      m_zero  = 1'b0;
      m_st[2] = m_st[1];
      m_st[1] = m_st[0];
      m_st[0] = '{v: in_valid, a: xs, b: ys, s: sgn};
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      m_adv = !(m_st[2].v && !out_ready);
      for (int d = 0; d < 5; d++) begin
        chk("out_valid", d, 64'(ov[d]), 64'(m_st[2].v));
        chk("in_ready", d, 64'(rdy[d]), 64'(m_adv));
        if (m_st[2].v)
          chk("product", d, dut_o(d), ref_prod(dw(d), m_st[2].a, m_st[2].b, m_st[2].s & se(d)));
        else if (m_zero)
          chk("reset_o", d, dut_o(d), 64'd0);
        if (!rst && out_ready && ov[d]) begin
          logq[d].push_back(dut_o(d));
          logc[d].push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 5; d++) begin
      logq[d].delete();
      logc[d].delete();
    end
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] b, logic s);
    in_valid = 1'b1;
    xs = a;
    ys = b;
    sgn = s;
  endtask

  // Offer one transaction and hold it until the 8-bit instance takes it
  task automatic send(logic [31:0] a, logic [31:0] b, logic s);
    logic acc;
    acc = 1'b0;
    drive(a, b, s);
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = rdy[1];
      step();
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 1, 64'd0, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sgn = 1'b0; xs = '0; ys = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Model pins
    chk("model_u4", 0, ref_prod(4, 32'd15, 32'd15, 1'b0), 64'hE1);
    chk("model_s4", 0, ref_prod(4, 32'h8, 32'h8, 1'b1), 64'h40);
    chk("model_s8", 1, ref_prod(8, 32'hFF, 32'hFF, 1'b1), 64'h0001);
    chk("model_s32", 3, ref_prod(32, 32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);

    // Single unsigned transaction: exact latency and one-cycle pulse
    drive(32'd15, 32'd15, 1'b0);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_out_valid", 0, 64'(ov[0]), 64'(k == 3));
      if (k == 3) chk("t1_o", 0, 64'(o4), 64'hE1);
    end

    // Three signed back-to-back, results on consecutive cycles
    step();
    clear_logs();
    c0 = cyc;
    drive(32'h8, 32'h8, 1'b1); step();
    drive(32'h8, 32'h7, 1'b1); step();
    drive(32'hF, 32'h1, 1'b1); step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("t2_count", 0, 64'(logq[0].size()), 64'd3);
    if (logq[0].size() == 3) begin
      chk("t2_o0", 0, logq[0][0], 64'h40);
      chk("t2_o1", 0, logq[0][1], 64'hC8);
      chk("t2_o2", 0, logq[0][2], 64'hFF);
      for (int k = 0; k < 3; k++) chk("t2_cycle", 0, 64'(logc[0][k]), 64'(c0 + 3 + k));
    end

    // Unsigned-only build ignores sgn
    clear_logs();
    drive(32'hFF, 32'hFF, 1'b1); step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("t6_count", 4, 64'(logq[4].size()), 64'd1);
    chk("t6_s_count", 1, 64'(logq[1].size()), 64'd1);
    if (logq[4].size() == 1) chk("t6_unsigned", 4, logq[4][0], 64'hFE01);
    if (logq[1].size() == 1) chk("t6_signed", 1, logq[1][0], 64'h0001);

    // Backpressure while streaming five transactions
    clear_logs();
    fork
      begin
        for (int k = 0; k < 14; k++) begin
          out_ready = !(k >= 3 && k <= 7);
          if (k == 5) begin
            @(negedge clk);
            chk("t3_hold_valid", 1, 64'(ov[1]), 64'd1);
            chk("t3_hold_o", 1, 64'(o8), 64'd3);
            chk("t3_stall_ready", 1, 64'(rdy[1]), 64'd0);
          end
          step();
        end
      end
      begin
        for (int n = 1; n <= 5; n++) send(32'(n), 32'd3, 1'b0);
      end
    join
    out_ready = 1'b1;
    repeat (8) step();
    chk("t3_count", 1, 64'(logq[1].size()), 64'd5);
    if (logq[1].size() == 5)
      for (int n = 0; n < 5; n++) chk("t3_order", 1, logq[1][n], 64'(3 * (n + 1)));

    // Reset with all stages full discards everything in flight
    clear_logs();
    drive(32'd7, 32'd9, 1'b0);  step();
    drive(32'd5, 32'd6, 1'b0);  step();
    drive(32'd3, 32'd11, 1'b0); step();
    out_ready = 1'b0;
    rst = 1'b1;
    drive(32'd2, 32'd2, 1'b0);
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t4_out_valid", 0, 64'(ov[0]), 64'd0);
    chk("t4_o4", 0, 64'(o4), 64'd0);
    chk("t4_o32", 3, o32, 64'd0);
    chk("t4_in_ready", 0, 64'(rdy[0]), 64'd1);
    repeat (10) step();
    for (int d = 0; d < 5; d++) chk("t4_no_output", d, 64'(logq[d].size()), 64'd0);

    // All 4-bit operand/sign combinations at full rate
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      drive({$urandom() & 32'hFFFF_FFF0} | 32'(vv[3:0]),
            {$urandom() & 32'hFFFF_FFF0} | 32'(vv[7:4]), vv[8]);
      step();
    end

    // Random operands with random valid and backpressure
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      xs  = $urandom();
      ys  = $urandom();
      sgn = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
